uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Single-clock UART transmitter and the transmit-side counterpart of the team's UART receive path. It accepts parallel bytes over a valid/ready handshake into a one-entry holding register. It serializes each byte as start, 8 data bits LSB first, optional parity, and stop onto tx_sdata_o, at CLKS_PER_BIT clocks per bit. Its frame format matches the 9-bit data-plus-parity word the receive path checks. It sits between upstream byte producers and the serial line.

Parameters:
CLKS_PER_BIT, 16, tx_sclk_i cycles per serial bit; legal minimum 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
tx_sclk_i  input  1  transmit clock; all logic on posedge.
tx_srst_i  input  1  reset; synchronous, active-high.
tx_pdata_i  input  8  byte to transmit.
tx_pdata_valid_i  input  1  tx_pdata_i valid.
tx_pready_o  output  1  holding register empty; byte accepted when valid && ready at a posedge.
tx_sdata_o  output  1  serial line; idle high; driven from a register (glitch-free).
tx_busy_o  output  1  high while FSM is not in IDLE or the holding register is full.

Behaviour:
- Reset (tx_srst_i high at posedge): FSM=IDLE, tx_sdata_o=1, tx_pready_o=1, tx_busy_o=0, holding register emptied, counters=0. Applies mid-frame: the line returns high on the next edge and the frame is aborted, not completed. Any held byte is discarded.
- Holding register: tx_pready_o = !hold_full, a registered flag with no combinational path from valid. An accept at edge N sets hold_full after N.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with hold_full: load the shift register from hold, clear hold_full, go to START, drive tx_sdata_o=0. Latency: accept at edge N gives the start bit on the line after edge N+1.
  - START: 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift_reg[0] for CLKS_PER_BIT cycles per bit, 8 bits LSB first. The bit counter runs 0..7; after bit 7 go to PARITY, or to STOP when parity is disabled.
  - PARITY: ^data XOR PARITY_ODD for CLKS_PER_BIT cycles, then STOP.
  - STOP: 1 for CLKS_PER_BIT cycles. On its last cycle, if hold_full, load directly into START with no idle gap. Otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on frame load.
- Frame length: 11*CLKS_PER_BIT cycles with parity, 10*CLKS_PER_BIT without.
- Back-to-back operation: while a frame is shifting, hold accepts the next byte, so tx_pready_o reasserts one cycle after the load. Sustained throughput is one frame per frame length.
- Stalls: tx_pdata_i and tx_pdata_valid_i are ignored while tx_pready_o=0. Upstream must hold them stable until accepted.
- Sampling: tx_pdata_i is captured only at accept; later changes have no effect on the frame in flight.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state is present and the frame is 11 bits, matching the receive path's 9-bit data+parity word.
- Undefined: the PARITY state and logic are removed, DATA goes directly to STOP, the frame is 10 bits, and PARITY_ODD is ignored.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4: tx_sdata_o=1, tx_pready_o=1, tx_busy_o=0 held for 100 cycles.
2. Accept 0xA5 at edge N, parity enabled, even: line low from N+1. Bits are 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1, each exactly 4 cycles, 44 cycles total. Then tx_busy_o=0.
3. Same as scenario 2 with PARITY_ODD=1 and byte 0x07: parity bit=0 (three ones XOR 1). Repeat with 0x00: parity bit=1.
4. Back-to-back 0x55 then 0xAA, valid held high: second accept lands 1 cycle after the first load. The 0xAA start bit begins on the cycle after the 0x55 stop bit's last cycle, with no idle gap.
5. Reset asserted during DATA bit 3 of 0x3C with 0x81 held: the line is high on the next edge, tx_pready_o=1, and no further frame is emitted.
6. UART_TX_PARITY_EN undefined, 0xFF: frame is 40 cycles at CLKS_PER_BIT=4, with the stop bit directly after data bit 7.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmitter: one-entry holding register feeding a start/data/stop framer.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_framer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic       tx_sclk_i,
   input  logic       tx_srst_i,
   input  logic [7:0] tx_pdata_i,
   input  logic       tx_pdata_valid_i,
   output logic       tx_pready_o,
   output logic       tx_sdata_o,
   output logic       tx_busy_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic [CW-1:0]   baud;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic [7:0]      hold;
   logic            hold_full;
   logic            sdata;
   logic            accept;
   logic            baud_end;
   logic            load;

`ifdef UART_TX_PARITY_EN
   logic            parity_bit;
`else
   logic            unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   assign accept   = tx_pdata_valid_i && !hold_full;
   assign baud_end = (baud == BAUD_LAST);
   // Load from hold when idle, or straight out of the last stop cycle.
   assign load     = hold_full &&
                     ((state == IDLE) ||
                      ((state == STOP) && baud_end));

   assign tx_pready_o = !hold_full;
   assign tx_sdata_o  = sdata;
   assign tx_busy_o   = (state != IDLE) || hold_full;

   // Holding register, baud/bit counters and frame sequencing.
   always_ff @(posedge tx_sclk_i) begin
      if (tx_srst_i) begin
         state     <= IDLE;
         baud      <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         sdata     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (accept) begin
            hold      <= tx_pdata_i;
            hold_full <= 1'b1;
         end
         if (load) begin
            shift_reg <= hold;
            hold_full <= 1'b0;
            state     <= START;
            sdata     <= 1'b0;
            baud      <= '0;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^hold) ^ (PARITY_ODD != 0);
`endif
         end else begin
            if (state != IDLE)
               baud <= baud_end ? '0 : baud + 1'b1;
            unique case (state)
               IDLE: begin
                  sdata <= 1'b1;
               end
               START: begin
                  if (baud_end) begin
                     state   <= DATA;
                     sdata   <= shift_reg[0];
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (baud_end) begin
                     if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        sdata <= parity_bit;
`else
                        state <= STOP;
                        sdata <= 1'b1;
`endif
                     end else begin
                        shift_reg <= shift_reg >> 1;
                        sdata     <= shift_reg[1];
                        bit_cnt   <= bit_cnt + 3'd1;
                     end
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  if (baud_end) begin
                     state <= STOP;
                     sdata <= 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (baud_end)
                     state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  sdata <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: even and odd parity instances
// driven in lockstep, frames checked cycle by cycle.
module tb_uart_tx_framer;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FCYC = FBITS * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic       rdy_e, sd_e, busy_e;
   logic       rdy_o, sd_o, busy_o;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] data;
      logic       par_even;
      logic       par_odd;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_even (
      .tx_sclk_i        (clk),
      .tx_srst_i        (rst),
      .tx_pdata_i       (data),
      .tx_pdata_valid_i (valid),
      .tx_pready_o      (rdy_e),
      .tx_sdata_o       (sd_e),
      .tx_busy_o        (busy_e)
   );

   uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_odd (
      .tx_sclk_i        (clk),
      .tx_srst_i        (rst),
      .tx_pdata_i       (data),
      .tx_pdata_valid_i (valid),
      .tx_pready_o      (rdy_o),
      .tx_sdata_o       (sd_o),
      .tx_busy_o        (busy_o)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input logic p,
                                    input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return p;
`endif
      return 1'b1;
   endfunction

   task automatic check_frame(input logic [7:0] d, input logic pe,
                              input logic po, input int last_cyc);
      for (int c = 0; c <= last_cyc; c++) begin
         @(negedge clk);
         chk("line_even", sd_e, exp_bit(d, pe, c / CPB));
         chk("line_odd", sd_o, exp_bit(d, po, c / CPB));
         chk("busy_frame", busy_e, 1'b1);
      end
   endtask

   task automatic check_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_line_e", sd_e, 1'b1);
         chk("idle_line_o", sd_o, 1'b1);
         chk("idle_ready", rdy_e, 1'b1);
         chk("idle_busy_e", busy_e, 1'b0);
         chk("idle_busy_o", busy_o, 1'b0);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      data  = d;
      valid = 1'b1;
      chk("ready_pre", rdy_e, 1'b1);
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      data  = ~d;
      chk("ready_post", rdy_e, 1'b0);
      chk("line_pre_start", sd_e, 1'b1);
      chk("busy_held", busy_e, 1'b1);
   endtask

   task automatic start_pair(input logic [7:0] d1, input logic [7:0] d2);
      @(negedge clk);
      data  = d1;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data = d2;
      chk("pair_ready_lo", rdy_e, 1'b0);
      chk("pair_line_hi", sd_e, 1'b1);
      fork
         begin
            @(posedge clk);
            @(negedge clk);
            chk("ready_reassert", rdy_e, 1'b1);
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            chk("ready_second", rdy_e, 1'b0);
         end
      join_none
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b0, 1'b1};
      vecs[4] = '{8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'h81, 1'b0, 1'b1};
      vecs[6] = '{8'h55, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 1'b1, 1'b0};

      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_line", sd_e, 1'b1);
      chk("rst_ready", rdy_e, 1'b1);
      chk("rst_busy", busy_e, 1'b0);
      rst = 1'b0;
      check_idle(100);

      for (int v = 0; v < 8; v++) begin
         send(vecs[v].data);
         check_frame(vecs[v].data, vecs[v].par_even, vecs[v].par_odd,
                     FCYC - 1);
         check_idle(3);
      end

      start_pair(8'h55, 8'hAA);
      check_frame(8'h55, 1'b0, 1'b1, FCYC - 1);
      check_frame(8'hAA, 1'b0, 1'b1, FCYC - 1);
      check_idle(4);

      start_pair(8'h3C, 8'h81);
      check_frame(8'h3C, 1'b0, 1'b1, 4 * CPB + 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_line_e", sd_e, 1'b1);
      chk("abort_line_o", sd_o, 1'b1);
      chk("abort_ready", rdy_e, 1'b1);
      chk("abort_busy", busy_e, 1'b0);
      rst = 1'b0;
      check_idle(60);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
